// File: rtl/mem_bus_def_pkg.sv
// ============================================================================
// Module      : mem_bus_def_pkg
// Description : Shared memory-bus definitions: widths, FSM states, legal BEs.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package mem_bus_def_pkg;

  localparam int unsigned BUS_DW = 32;
  localparam int unsigned BUS_AW = 32;
  localparam int unsigned BUS_BW = BUS_DW / 8;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_WAIT = 2'd1;
  localparam logic [1:0] ST_RESP = 2'd2;

  localparam logic [3:0] BE_B0   = 4'b0001;
  localparam logic [3:0] BE_B1   = 4'b0010;
  localparam logic [3:0] BE_B2   = 4'b0100;
  localparam logic [3:0] BE_B3   = 4'b1000;
  localparam logic [3:0] BE_HLO  = 4'b0011;
  localparam logic [3:0] BE_HHI  = 4'b1100;
  localparam logic [3:0] BE_WORD = 4'b1111;

  function automatic logic be_legal(input logic [3:0] be);
    return (be == BE_B0)  || (be == BE_B1)  || (be == BE_B2) || (be == BE_B3) ||
           (be == BE_HLO) || (be == BE_HHI) || (be == BE_WORD);
  endfunction

endpackage

`default_nettype wire

// File: rtl/mem_bus_sram.sv
// ============================================================================
// Module      : mem_bus_sram
// Description : Single-port synchronous RAM, per-byte write enable, registered read.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module mem_bus_sram
  import mem_bus_def_pkg::*;
#(
  parameter int unsigned DEPTH_WORDS = 1024,
  parameter int unsigned ADDR_W      = $clog2(DEPTH_WORDS)
) (
  input  logic              i_clk,
  input  logic [BUS_BW-1:0] i_we,
  input  logic              i_re,
  input  logic [ADDR_W-1:0] i_addr,
  input  logic [BUS_DW-1:0] i_wdata,
  output logic [BUS_DW-1:0] o_rdata
);

  logic [BUS_DW-1:0] mem_q [DEPTH_WORDS];
  logic [BUS_DW-1:0] rdata_q;

  always_ff @(posedge i_clk) begin
    for (int n = 0; n < int'(BUS_BW); n++) begin
      if (i_we[n]) begin
        mem_q[i_addr][n*8 +: 8] <= i_wdata[n*8 +: 8];
      end
    end
    // Output register only moves on a read so the last read word is held.
    if (i_re) begin
      rdata_q <= mem_q[i_addr];
    end
  end

  assign o_rdata = rdata_q;

endmodule

`default_nettype wire

// File: rtl/mem_bus_responder.sv
// ============================================================================
// Module      : mem_bus_responder
// Description : Memory-bus responder with wait states and one-cycle ready.
//               Optional address/BE error checking: MEM_BUS_RESPONDER_ERR_EN.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module mem_bus_responder
  import mem_bus_def_pkg::*;
#(
  parameter int unsigned       DEPTH_WORDS = 1024,
  parameter int unsigned       WAIT_CYCLES = 1,
  parameter logic [BUS_AW-1:0] BASE_ADDR   = 32'h0000_0000
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_bus_req,
  input  logic              i_bus_we,
  input  logic [BUS_BW-1:0] i_bus_be,
  input  logic [BUS_AW-1:0] i_bus_addr,
  input  logic [BUS_DW-1:0] i_bus_data,
  output logic [BUS_DW-1:0] o_bus_data,
  output logic              o_bus_ready,
  output logic              o_bus_err
);

  localparam int unsigned ADDR_W      = $clog2(DEPTH_WORDS);
  localparam logic [3:0]  WAIT_LOAD   = (WAIT_CYCLES > 0) ? 4'(WAIT_CYCLES - 1) : 4'd0;
  localparam logic [1:0]  ACCEPT_NEXT = (WAIT_CYCLES > 0) ? ST_WAIT : ST_RESP;
  localparam logic        NO_WAIT     = (WAIT_CYCLES == 0);

  logic [1:0]        state_q, state_d;
  logic [3:0]        cnt_q, cnt_d;
  logic              we_q;
  logic              err_q;
  logic              zero_q;
  logic [ADDR_W-1:0] idx_q;

  logic              w_accept;
  logic              w_wait_done;
  logic              w_err_in;
  logic              w_rd_event;
  logic              w_rd_err;
  logic [ADDR_W-1:0] w_idx_in;
  logic [BUS_BW-1:0] w_ram_we;
  logic              w_ram_re;
  logic [ADDR_W-1:0] w_ram_addr;
  logic [BUS_DW-1:0] w_ram_rdata;

  assign w_idx_in = ADDR_W'((i_bus_addr - BASE_ADDR) >> 2);

`ifdef MEM_BUS_RESPONDER_ERR_EN
  logic [BUS_AW-1:0] w_offset;
  assign w_offset = i_bus_addr - BASE_ADDR;
  assign w_err_in = (i_bus_addr[1:0] != 2'b00) ||
                    (i_bus_we && !be_legal(i_bus_be)) ||
                    ({1'b0, w_offset} >= (33'(DEPTH_WORDS) << 2));
`else
  assign w_err_in = 1'b0;
`endif

  assign w_accept    = !i_rst && i_bus_req && ((state_q == ST_IDLE) || (state_q == ST_RESP));
  assign w_wait_done = (state_q == ST_WAIT) && (cnt_q == 4'd0);

  // Reads enter RESP either straight from acceptance (no wait states) or from WAIT.
  assign w_rd_event = (w_accept && !i_bus_we && NO_WAIT) || (!i_rst && w_wait_done && !we_q);
  assign w_rd_err   = w_accept ? w_err_in : err_q;

  assign w_ram_we   = (w_accept && i_bus_we && !w_err_in) ? i_bus_be : '0;
  assign w_ram_re   = w_rd_event && !w_rd_err;
  assign w_ram_addr = w_accept ? w_idx_in : idx_q;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      ST_IDLE: begin
        if (w_accept) begin
          state_d = ACCEPT_NEXT;
          cnt_d   = WAIT_LOAD;
        end
      end
      ST_WAIT: begin
        if (cnt_q == 4'd0) begin
          state_d = ST_RESP;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      ST_RESP: begin
        if (w_accept) begin
          state_d = ACCEPT_NEXT;
          cnt_d   = WAIT_LOAD;
        end else begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= 4'd0;
      we_q    <= 1'b0;
      err_q   <= 1'b0;
      zero_q  <= 1'b1;
      idx_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (w_accept) begin
        we_q  <= i_bus_we;
        err_q <= w_err_in;
        idx_q <= w_idx_in;
      end
      if (w_rd_event) begin
        zero_q <= w_rd_err;
      end
    end
  end

  mem_bus_sram #(
    .DEPTH_WORDS (DEPTH_WORDS),
    .ADDR_W      (ADDR_W)
  ) u_sram (
    .i_clk   (i_clk),
    .i_we    (w_ram_we),
    .i_re    (w_ram_re),
    .i_addr  (w_ram_addr),
    .i_wdata (i_bus_data),
    .o_rdata (w_ram_rdata)
  );

  assign o_bus_ready = (state_q == ST_RESP);
  assign o_bus_err   = o_bus_ready && err_q;
  assign o_bus_data  = zero_q ? '0 : w_ram_rdata;

endmodule

`default_nettype wire

// File: doc/mem_bus_responder.md
Name: mem_bus_responder

Overview:
Responder (slave) end of the core's memory bus: accepts single-beat read/write requests from the core's memory interface and serves them from an internal word-addressed RAM with byte-lane writes. One instance serves the data bus; a second, write-disabled by the initiator, serves the instruction bus. A programmable wait-state counter models slow memory, and each response is a one-cycle ready pulse.

Parameters:
DEPTH_WORDS, 1024, number of 32-bit words in the array (power of two, at least 2).
WAIT_CYCLES, 1, extra cycles between request acceptance and the ready pulse (0..15).
BASE_ADDR, 32'h0000_0000, byte address that maps to word 0 (must be aligned to DEPTH_WORDS*4).

Ports:
i_clk  in  1  clock, rising edge.
i_rst  in  1  synchronous active-high reset.
i_bus_req  in  1  request valid.
i_bus_we  in  1  1=write, 0=read.
i_bus_be  in  4  byte enables; bit n selects data[8n+7:8n].
i_bus_addr  in  32  byte address.
i_bus_data  in  32  write data, lane-aligned.
o_bus_data  out  32  read data; valid while o_bus_ready=1.
o_bus_ready  out  1  one-cycle response pulse.
o_bus_err  out  1  error flag; valid only with o_bus_ready.

Behaviour:
- Clocking: one clock (i_clk). Reset i_rst is synchronous and active-high. Reset values: o_bus_ready=0, o_bus_err=0, o_bus_data=0, FSM=IDLE, wait counter=0. RAM contents are not reset.
- FSM states: IDLE, WAIT, RESP.
- IDLE with i_bus_req=1: accept the request and latch we, be, addr and data. Next state is WAIT if WAIT_CYCLES>0, otherwise RESP. The counter loads WAIT_CYCLES-1.
- WAIT: counter decrements each cycle. At 0, go to RESP.
- RESP: o_bus_ready=1 for exactly this cycle. If i_bus_req=1 in this cycle, accept the new request (back-to-back). Otherwise return to IDLE.
- Latency: a request accepted at the edge ending cycle T produces ready in cycle T+1+WAIT_CYCLES. Peak throughput is one transaction per WAIT_CYCLES+1 cycles.
- i_bus_req is ignored in WAIT. There is no queueing; the initiator holds its request until it is accepted.
- Write commit: the RAM is written on the acceptance edge, only for lanes with be=1. Unselected lanes keep their old value.
- Read capture: the word is read on the edge entering RESP and driven on o_bus_data. o_bus_data holds that value until the next read response. Writes leave o_bus_data unchanged.
- Read-after-write: a read accepted in the RESP cycle of a write to the same word returns the new data.
- Word index: (addr-BASE_ADDR)>>2.
- Legal byte enables: 4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0011, 4'b1100, 4'b1111.
- i_bus_be is ignored on reads; the full word is always returned.
- Reset mid-transaction: the pending response is dropped and no ready is issued. A write already committed at acceptance remains in the RAM.
- Reset asserted in the same cycle as a request: reset wins and the request is not accepted.

Optional Feature:
MEM_BUS_RESPONDER_ERR_EN.
- Defined: o_bus_err=1 with ready when any of the following holds:
  - addr[1:0]!=0;
  - a write uses an illegal be pattern;
  - addr is outside [BASE_ADDR, BASE_ADDR+DEPTH_WORDS*4).
  An erroring write is suppressed. An erroring read returns o_bus_data=0.
- Undefined: o_bus_err is tied to 0. addr[1:0] is ignored. The word index wraps modulo DEPTH_WORDS. Illegal be patterns write the selected lanes as given.

Decomposition:
- Shared definitions file (mem_bus_def): state encodings, legal-BE constants, bus width constants (32-bit data/address).
- One sub-module: mem_bus_sram, a single-port synchronous RAM with a 4-bit byte write enable and a registered read. The FSM, counter and error logic stay in mem_bus_responder.

Test Plan:
- Reset then read: i_rst for 2 cycles, then read addr 0x10 with WAIT_CYCLES=1 -> ready exactly 2 cycles after acceptance, err=0; ready and data are 0 during reset.
- Byte lanes: write 0xAABBCCDD be=1111 at 0x20, then write 0x00001100 be=0010 -> a read of 0x20 returns 0xAABB11DD.
- Back-to-back: with WAIT_CYCLES=0, hold req as write 0x30=0x12345678 then read 0x30 -> ready on consecutive cycles, read data 0x12345678.
- Wait states: WAIT_CYCLES=3, read -> ready in cycle T+4. A second req asserted during WAIT is not accepted until RESP.
- Reset mid-operation: WAIT_CYCLES=3, assert i_rst in the first WAIT cycle -> no ready pulse, FSM back in IDLE. A write accepted earlier is still readable afterwards.
- Errors (macro defined): read at 0x22, and a write with be=0101 -> ready with err=1. The RAM word is unchanged; the erroring read returns 0. With the macro undefined, the same stimulus gives err=0.
